// File: rtl/ysyx_22050133_ifu_if.sv
// Fetch-stage bus bundle: memory read port, execute redirect and decode handoff.
// The master modport is the IFU side; the slave modport is the environment side.
interface ysyx_22050133_ifu_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [63:0] if_pc;

  modport master (
    output mem_req_valid, mem_req_addr, if_valid, if_inst, if_pc,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, if_valid, if_inst, if_pc,
    output mem_req_ready, mem_resp_valid, mem_resp_data, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/ysyx_22050133_ifu.sv
// Instruction fetch unit: one outstanding read, single-entry instruction buffer, redirect kill.
// Define YSYX_22050133_IFU_PERF_EN to add the fetch/stall performance counters.
module ysyx_22050133_ifu #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst,
  ysyx_22050133_ifu_if.master bus
`ifdef YSYX_22050133_IFU_PERF_EN
  ,
  output logic [63:0]         perf_fetch_cnt,
  output logic [63:0]         perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state;
  logic [63:0] pc;
  logic        kill;
  logic [31:0] inst_buf;
  logic        req_valid;
  logic        hold_valid;
  logic [63:0] redirect_target;
  logic [31:0] resp_word;
  logic        unused_redirect_lsb;

  assign redirect_target     = {bus.redirect_pc[63:2], 2'b00};
  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];
  assign resp_word           = pc[2] ? bus.mem_resp_data[63:32] : bus.mem_resp_data[31:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      kill       <= 1'b0;
      inst_buf   <= NOP_INST;
      req_valid  <= 1'b1;
      hold_valid <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (bus.redirect_valid) pc <= redirect_target;
          // An accepted request alongside a redirect fetches a stale address; kill its response.
          if (bus.mem_req_ready) begin
            state     <= S_WAIT;
            req_valid <= 1'b0;
            kill      <= bus.redirect_valid;
          end
        end
        S_WAIT: begin
          if (bus.mem_resp_valid) begin
            if (kill || bus.redirect_valid) begin
              kill      <= 1'b0;
              if (bus.redirect_valid) pc <= redirect_target;
              state     <= S_REQ;
              req_valid <= 1'b1;
            end else begin
              inst_buf   <= resp_word;
              state      <= S_HOLD;
              hold_valid <= 1'b1;
            end
          end else if (bus.redirect_valid) begin
            pc   <= redirect_target;
            kill <= 1'b1;
          end
        end
        S_HOLD: begin
          if (bus.redirect_valid || bus.id_ready) begin
            pc         <= bus.redirect_valid ? redirect_target : pc + 64'd4;
            inst_buf   <= NOP_INST;
            state      <= S_REQ;
            req_valid  <= 1'b1;
            hold_valid <= 1'b0;
          end
        end
        default: begin
          state      <= S_REQ;
          req_valid  <= 1'b1;
          hold_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = {pc[63:3], 3'b000};
  assign bus.if_valid      = hold_valid;
  assign bus.if_inst       = inst_buf;
  assign bus.if_pc         = pc;

`ifdef YSYX_22050133_IFU_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= 64'd0;
      perf_stall_cnt <= 64'd0;
    end else begin
      if (hold_valid && bus.id_ready && !bus.redirect_valid) perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      if (hold_valid && !bus.id_ready) perf_stall_cnt <= perf_stall_cnt + 64'd1;
    end
  end
`endif

endmodule
